reg_coherence_manager: RTL and testbench
========================================

# reg_coherence_manager

N-core generalisation of the dual-issue register management block. It tracks which core holds the newest copy of each architectural register and arbitrates register claims from several cores. It produces a merged register file for the multi-processor manager and emits per-core synchronisation pulses once a core's view is stale. It sits between the processor cores and the multi-processor manager.

## Interface
- NUM_CORES, 2: number of processor cores (2..8)
- REG_COUNT, 32: architectural registers per core
- REG_WIDTH, 64: register width in bits
- PINNED_REG, 1: register always sourced from `ra_value`; never claimable
- REG_IDX_W, $clog2(REG_COUNT): register index width
- CORE_W, max(1,$clog2(NUM_CORES)): core index width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- core_regs  in  [NUM_CORES][REG_COUNT] x REG_WIDTH  per-core register files
- core_idle  in  NUM_CORES  core c is idle when high
- claim_valid  in  NUM_CORES  core c requests ownership of `claim_reg[c]`
- claim_reg  in  [NUM_CORES] x REG_IDX_W  register index per claim
- claim_ready  out  NUM_CORES  claim accepted on valid&ready
- ra_value  in  REG_WIDTH  value for PINNED_REG
- merged_regs  out  [REG_COUNT] x REG_WIDTH  newest value of every register
- owner  out  [REG_COUNT] x CORE_W  core holding newest copy
- busy_table  out  REG_COUNT  register claimed, update in flight
- sync_pulse  out  NUM_CORES  one-cycle pulse: core c must reload `merged_regs`
- all_synced  out  1  no core holds a stale view

## Operation
- Per-core FSM states: IDLE, ARMED, RUNNING, SYNC.
- IDLE to ARMED on an accepted claim. Store the index in `reg_buf[c]` and set `busy_table[idx]`.
- ARMED to RUNNING when `core_idle[c]`=0.
- RUNNING to IDLE when `core_idle[c]`=1. This is a completion: `owner[reg_buf[c]]`<=c, busy bit cleared, `stale[k]`<=1 for every k≠c.
- `claim_ready[c]` is combinational. It is high when all of the following hold:
  - core c is in IDLE;
  - `busy_table[claim_reg[c]]`=0;
  - `claim_reg[c]`≠PINNED_REG;
  - `stale[c]`=0;
  - no lower-index core presents a valid claim on the same index this cycle (fixed priority, core 0 highest).
- Sync: core c enters SYNC from IDLE when all of the following hold:
  - `stale[c]`=1;
  - `claim_valid[c]`=0;
  - no core is in ARMED or RUNNING.
- SYNC lasts exactly 1 cycle: `sync_pulse[c]`=1, `stale[c]` cleared, then return to IDLE.
- Stale cores sync concurrently.
- `all_synced` = NOR of `stale[]`.
- `merged_regs[PINNED_REG]` = `ra_value`. For every other r, `merged_regs[r]` = `core_regs[owner[r]][r]`.
- Simultaneous completions by several cores:
  - all owner updates apply;
  - each completer's stale bit is set by the other completer(s).
- Completion and claim on the same register in the same cycle: the claim is rejected (busy still high) and may be retried next cycle.
- Reset (any time, including mid-operation):
  - FSMs go to IDLE;
  - owner of every register = 0;
  - busy_table = 0, stale = 0, sync_pulse = 0, all_synced = 1;
  - in-flight claims are discarded.

## Timing
- Accepted claim at edge T: busy_table and state ARMED visible after T.
- Completion detected at edge T: owner, busy and stale update after T. `merged_regs` follows combinationally in the same cycle.
- Earliest sync_pulse: 1 cycle after the completion edge, if no other core is active.
- claim_ready and merged_regs are purely combinational. All other outputs are registered.

## Structure
- Package `reg_coh_pkg` holds:
  - core FSM state enum (IDLE=0, ARMED=1, RUNNING=2, SYNC=3);
  - the CORE_W computation function.
- Sub-module `reg_coh_core_fsm`, one instance per core:
  - holds the state, `reg_buf` and `stale`;
  - outputs a completion strobe plus the register index.
- The top level holds the owner array, busy table, claim arbitration and merge mux.

## Test plan
- NUM_CORES=2, core 1 claims r5 while core 0 runs nothing → core 1 goes ARMED then RUNNING; on core_idle[1]=1, owner[5]=1, busy[5]=0, then sync_pulse[0] for 1 cycle, all_synced=1.
- Cores 0 and 2 (NUM_CORES=4) claim r7 in the same cycle → only claim_ready[0]=1; core 2 is accepted after core 0 completes.
- Claim of r1 with PINNED_REG=1 → claim_ready=0; merged_regs[1] tracks ra_value=0xDEAD.
- Cores 1 and 3 complete r4 and r9 in the same cycle → owner[4]=1, owner[9]=3; all four cores pulse sync once, in the same cycle.
- Assert rst_n low while core 2 is RUNNING on r3 → busy[3]=0, owner[3]=0, sync_pulse=0; a new claim on r3 is accepted immediately after release.
- Stale core holds claim_valid=1 → no sync_pulse until claim_valid drops; the claim is not accepted while stale.

Source files
------------

// File: rtl/reg_coh_pkg.sv
// Shared types for the register coherence manager: per-core FSM states and
// the core-index width helper.
package reg_coh_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    SYNC    = 2'd3
  } core_state_e;

  // A single core still needs a one-bit owner field.
  function automatic int calc_core_w(input int num_cores);
    return (num_cores > 1) ? $clog2(num_cores) : 1;
  endfunction

endpackage

// File: rtl/reg_coh_core_fsm.sv
// Per-core claim lifecycle: tracks the claimed register, the core's stale flag
// and the one-cycle resynchronisation state.
module reg_coh_core_fsm
  import reg_coh_pkg::*;
#(
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 claim_accept,
  input  logic [REG_IDX_W-1:0] claim_reg,
  input  logic                 claim_valid,
  input  logic                 core_idle,
  input  logic                 any_active,
  input  logic                 stale_set,
  output logic                 idle,
  output logic                 active,
  output logic                 stale,
  output logic                 complete,
  output logic [REG_IDX_W-1:0] complete_reg,
  output logic                 sync_pulse
);

  core_state_e          state;
  core_state_e          state_next;
  logic [REG_IDX_W-1:0] reg_buf;

  always_comb begin
    // NOTE: default first so no branch leaves state_next unassigned; a missing
    // assignment in always_comb infers a latch.
    state_next = state;
    case (state)
      IDLE: begin
        if (claim_accept) begin
          state_next = ARMED;
        end else if (stale && !claim_valid && !any_active) begin
          state_next = SYNC;
        end
      end
      ARMED:   if (!core_idle) state_next = RUNNING;
      RUNNING: if (core_idle)  state_next = IDLE;
      SYNC:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      reg_buf <= '0;
      stale   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop here samples pre-edge values,
      // independent of statement order.
      state <= state_next;
      if (claim_accept) begin
        reg_buf <= claim_reg;
      end
      // A fresh completion elsewhere outranks the clear at the end of SYNC.
      if (stale_set) begin
        stale <= 1'b1;
      end else if (state == SYNC) begin
        stale <= 1'b0;
      end
    end
  end

  assign idle         = (state == IDLE);
  assign active       = (state == ARMED) || (state == RUNNING);
  assign complete     = (state == RUNNING) && core_idle;
  assign complete_reg = reg_buf;
  assign sync_pulse   = (state == SYNC);

endmodule

// File: rtl/reg_coherence_manager.sv
// Tracks the newest copy of every architectural register across N cores,
// arbitrates ownership claims and signals cores whose view has gone stale.
module reg_coherence_manager
  import reg_coh_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int REG_COUNT  = 32,
  parameter int REG_WIDTH  = 64,
  parameter int PINNED_REG = 1,
  parameter int REG_IDX_W  = $clog2(REG_COUNT),
  parameter int CORE_W     = calc_core_w(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_WIDTH-1:0] core_regs [NUM_CORES][REG_COUNT],
  input  logic [NUM_CORES-1:0] core_idle,
  input  logic [NUM_CORES-1:0] claim_valid,
  input  logic [REG_IDX_W-1:0] claim_reg [NUM_CORES],
  output logic [NUM_CORES-1:0] claim_ready,
  input  logic [REG_WIDTH-1:0] ra_value,
  output logic [REG_WIDTH-1:0] merged_regs [REG_COUNT],
  output logic [CORE_W-1:0]    owner [REG_COUNT],
  output logic [REG_COUNT-1:0] busy_table,
  output logic [NUM_CORES-1:0] sync_pulse,
  output logic                 all_synced
);

  logic [NUM_CORES-1:0] idle;
  logic [NUM_CORES-1:0] active;
  logic [NUM_CORES-1:0] stale;
  logic [NUM_CORES-1:0] complete;
  logic [NUM_CORES-1:0] claim_accept;
  logic [NUM_CORES-1:0] stale_set;
  logic [NUM_CORES-1:0] lower_conflict;
  logic [REG_IDX_W-1:0] complete_reg [NUM_CORES];
  logic                 any_active;

  assign any_active   = |active;
  assign all_synced   = ~|stale;
  assign claim_accept = claim_valid & claim_ready;

  // Fixed priority: any lower-index valid claim on the same index blocks us.
  always_comb begin
    lower_conflict = '0;
    for (int c = 1; c < NUM_CORES; c++) begin
      for (int j = 0; j < c; j++) begin
        if (claim_valid[j] && (claim_reg[j] == claim_reg[c])) begin
          lower_conflict[c] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    claim_ready = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      claim_ready[c] = idle[c] && !stale[c] && !lower_conflict[c]
                    && (int'(claim_reg[c]) < REG_COUNT)
                    && (int'(claim_reg[c]) != PINNED_REG)
                    && !busy_table[claim_reg[c]];
    end
  end

  // Every completion marks all other cores stale, including other completers.
  always_comb begin
    stale_set = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      stale_set[k] = |(complete & ~(NUM_CORES'(1) << k));
    end
  end

  // A claim can never target a busy register, so a clear and a set in the
  // same cycle always hit different bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_table <= '0;
      // NOTE: owner is a flop array rather than a RAM because it must clear on
      // reset; a memory macro could not provide that.
      for (int r = 0; r < REG_COUNT; r++) begin
        owner[r] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (complete[c]) begin
          busy_table[complete_reg[c]] <= 1'b0;
          owner[complete_reg[c]]      <= CORE_W'(c);
        end
        if (claim_accept[c]) begin
          busy_table[claim_reg[c]] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < REG_COUNT; r++) begin
      merged_regs[r] = (r == PINNED_REG) ? ra_value : core_regs[owner[r]][r];
    end
  end

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    reg_coh_core_fsm #(
      .REG_IDX_W (REG_IDX_W)
    ) u_fsm (
      .clk          (clk),
      .rst_n        (rst_n),
      .claim_accept (claim_accept[c]),
      .claim_reg    (claim_reg[c]),
      .claim_valid  (claim_valid[c]),
      .core_idle    (core_idle[c]),
      .any_active   (any_active),
      .stale_set    (stale_set[c]),
      .idle         (idle[c]),
      .active       (active[c]),
      .stale        (stale[c]),
      .complete     (complete[c]),
      .complete_reg (complete_reg[c]),
      .sync_pulse   (sync_pulse[c])
    );
  end

endmodule

// File: tb/tb_reg_coherence_manager.sv
// Scenario bench for reg_coherence_manager with four cores: expected owner
// updates and sync pulse masks are queued at stimulus time and checked on output.
module tb_reg_coherence_manager;

  localparam int NC = 4;
  localparam int RC = 32;
  localparam int RW = 64;
  localparam int IW = 5;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic [RW-1:0] core_regs [NC][RC];
  logic [NC-1:0] core_idle;
  logic [NC-1:0] claim_valid;
  logic [IW-1:0] claim_reg [NC];
  logic [NC-1:0] claim_ready;
  logic [RW-1:0] ra_value;
  logic [RW-1:0] merged_regs [RC];
  logic [CW-1:0] owner [RC];
  logic [RC-1:0] busy_table;
  logic [NC-1:0] sync_pulse;
  logic          all_synced;

  typedef struct {
    int idx;
    int core;
  } own_exp_t;

  own_exp_t      own_q[$];
  logic [NC-1:0] sync_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  reg_coherence_manager #(
    .NUM_CORES  (NC),
    .REG_COUNT  (RC),
    .REG_WIDTH  (RW),
    .PINNED_REG (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_regs   (core_regs),
    .core_idle   (core_idle),
    .claim_valid (claim_valid),
    .claim_reg   (claim_reg),
    .claim_ready (claim_ready),
    .ra_value    (ra_value),
    .merged_regs (merged_regs),
    .owner       (owner),
    .busy_table  (busy_table),
    .sync_pulse  (sync_pulse),
    .all_synced  (all_synced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for any sync pulse; cycles = -1 when none arrives.
  task automatic wait_sync(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (sync_pulse !== '0) begin
        cycles = i;
        return;
      end
    end
  endtask

  task automatic pop_owners(input string tag);
    own_exp_t oe;
    while (own_q.size() > 0) begin
      oe = own_q.pop_front();
      n_checks++;
      if (owner[oe.idx] !== CW'(oe.core)) begin
        n_fail++;
        $display("FAIL %s_owner[%0d]: got %0d expected %0d", tag, oe.idx, owner[oe.idx], oe.core);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    n_checks++; if (busy_table !== '0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", busy_table); end
    n_checks++; if (sync_pulse !== '0) begin n_fail++; $display("FAIL reset_sync: got %b expected 0", sync_pulse); end
    n_checks++; if (all_synced !== 1'b1) begin n_fail++; $display("FAIL reset_all_synced: got %b expected 1", all_synced); end
    for (int r = 0; r < RC; r += 8) begin
      n_checks++; if (owner[r] !== '0) begin n_fail++; $display("FAIL reset_owner[%0d]: got %0d expected 0", r, owner[r]); end
    end
    n_checks++; if (merged_regs[5] !== core_regs[0][5]) begin n_fail++; $display("FAIL reset_merged5: got %h expected %h", merged_regs[5], core_regs[0][5]); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_claim();
    int            cyc;
    logic [NC-1:0] exp_sync;
    claim_reg[1] = 5; claim_valid[1] = 1'b1;
    #1;
    n_checks++; if (claim_ready[1] !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", claim_ready[1]); end
    tick();
    claim_valid[1] = 1'b0;
    #1;
    n_checks++; if (busy_table[5] !== 1'b1) begin n_fail++; $display("FAIL single_busy_set: got %b expected 1", busy_table[5]); end
    n_checks++; if (claim_ready[1] !== 1'b0) begin n_fail++; $display("FAIL single_ready_armed: got %b expected 0", claim_ready[1]); end
    core_idle[1] = 1'b0;
    tick();
    core_idle[1] = 1'b1;
    own_q.push_back('{idx: 5, core: 1});
    sync_q.push_back(4'b1101);
    tick();
    pop_owners("single");
    n_checks++; if (busy_table[5] !== 1'b0) begin n_fail++; $display("FAIL single_busy_clr: got %b expected 0", busy_table[5]); end
    n_checks++; if (merged_regs[5] !== core_regs[1][5]) begin n_fail++; $display("FAIL single_merged5: got %h expected %h", merged_regs[5], core_regs[1][5]); end
    n_checks++; if (all_synced !== 1'b0) begin n_fail++; $display("FAIL single_stale: got %b expected 0", all_synced); end
    n_checks++; if (sync_pulse !== '0) begin n_fail++; $display("FAIL single_no_early_sync: got %b expected 0", sync_pulse); end
    wait_sync(cyc);
    exp_sync = sync_q.pop_front();
    n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL single_sync_latency: got %0d expected 1", cyc); end
    n_checks++; if (sync_pulse !== exp_sync) begin n_fail++; $display("FAIL single_sync_mask: got %b expected %b", sync_pulse, exp_sync); end
    tick();
    n_checks++; if (sync_pulse !== '0) begin n_fail++; $display("FAIL single_sync_width: got %b expected 0", sync_pulse); end
    n_checks++; if (all_synced !== 1'b1) begin n_fail++; $display("FAIL single_all_synced: got %b expected 1", all_synced); end
  endtask

  task automatic test_priority_and_stale();
    int            cyc;
    logic [NC-1:0] exp_sync;
    claim_reg[0] = 7; claim_reg[2] = 7;
    claim_valid[0] = 1'b1; claim_valid[2] = 1'b1;
    #1;
    n_checks++; if (claim_ready[0] !== 1'b1) begin n_fail++; $display("FAIL prio_ready0: got %b expected 1", claim_ready[0]); end
    n_checks++; if (claim_ready[2] !== 1'b0) begin n_fail++; $display("FAIL prio_ready2: got %b expected 0", claim_ready[2]); end
    tick();
    claim_valid[0] = 1'b0;
    #1;
    n_checks++; if (busy_table[7] !== 1'b1) begin n_fail++; $display("FAIL prio_busy7: got %b expected 1", busy_table[7]); end
    n_checks++; if (claim_ready[2] !== 1'b0) begin n_fail++; $display("FAIL prio_ready2_busy: got %b expected 0", claim_ready[2]); end
    core_idle[0] = 1'b0;
    tick();
    core_idle[0] = 1'b1;
    own_q.push_back('{idx: 7, core: 0});
    sync_q.push_back(4'b1010);
    tick();
    pop_owners("prio0");
    n_checks++; if (claim_ready[2] !== 1'b0) begin n_fail++; $display("FAIL prio_ready2_stale: got %b expected 0", claim_ready[2]); end
    wait_sync(cyc);
    exp_sync = sync_q.pop_front();
    n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL prio_sync_latency: got %0d expected 1", cyc); end
    n_checks++; if (sync_pulse !== exp_sync) begin n_fail++; $display("FAIL prio_sync_mask: got %b expected %b", sync_pulse, exp_sync); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (sync_pulse !== '0 || claim_ready[2] !== 1'b0) begin n_fail++; $display("FAIL stale_hold_%0d: sync %b ready2 %b expected 0 0", i, sync_pulse, claim_ready[2]); end
    end
    claim_valid[2] = 1'b0;
    sync_q.push_back(4'b0100);
    wait_sync(cyc);
    exp_sync = sync_q.pop_front();
    n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL stale_sync_latency: got %0d expected 1", cyc); end
    n_checks++; if (sync_pulse !== exp_sync) begin n_fail++; $display("FAIL stale_sync_mask: got %b expected %b", sync_pulse, exp_sync); end
    tick();
    n_checks++; if (all_synced !== 1'b1) begin n_fail++; $display("FAIL stale_all_synced: got %b expected 1", all_synced); end
    claim_valid[2] = 1'b1;
    #1;
    n_checks++; if (claim_ready[2] !== 1'b1) begin n_fail++; $display("FAIL prio_retry_ready2: got %b expected 1", claim_ready[2]); end
    tick();
    claim_valid[2] = 1'b0;
    core_idle[2] = 1'b0;
    tick();
    core_idle[2] = 1'b1;
    own_q.push_back('{idx: 7, core: 2});
    sync_q.push_back(4'b1011);
    tick();
    pop_owners("prio2");
    n_checks++; if (merged_regs[7] !== core_regs[2][7]) begin n_fail++; $display("FAIL prio_merged7: got %h expected %h", merged_regs[7], core_regs[2][7]); end
    wait_sync(cyc);
    exp_sync = sync_q.pop_front();
    n_checks++; if (sync_pulse !== exp_sync) begin n_fail++; $display("FAIL prio2_sync_mask: got %b expected %b", sync_pulse, exp_sync); end
    tick();
  endtask

  task automatic test_pinned();
    claim_reg[0] = 1; claim_valid[0] = 1'b1;
    ra_value = 64'hDEAD;
    #1;
    n_checks++; if (claim_ready[0] !== 1'b0) begin n_fail++; $display("FAIL pinned_ready: got %b expected 0", claim_ready[0]); end
    n_checks++; if (merged_regs[1] !== 64'hDEAD) begin n_fail++; $display("FAIL pinned_merged_dead: got %h expected dead", merged_regs[1]); end
    tick();
    n_checks++; if (busy_table[1] !== 1'b0) begin n_fail++; $display("FAIL pinned_busy: got %b expected 0", busy_table[1]); end
    ra_value = 64'h1234_5678_9ABC_DEF0;
    #1;
    n_checks++; if (merged_regs[1] !== 64'h1234_5678_9ABC_DEF0) begin n_fail++; $display("FAIL pinned_merged_track: got %h expected 123456789abcdef0", merged_regs[1]); end
    claim_valid[0] = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    int            cyc;
    logic [NC-1:0] exp_sync;
    claim_reg[1] = 4; claim_reg[3] = 9;
    claim_valid[1] = 1'b1; claim_valid[3] = 1'b1;
    #1;
    n_checks++; if ({claim_ready[3], claim_ready[1]} !== 2'b11) begin n_fail++; $display("FAIL sim_ready: got %b expected 11", {claim_ready[3], claim_ready[1]}); end
    tick();
    claim_valid[1] = 1'b0; claim_valid[3] = 1'b0;
    core_idle[1] = 1'b0; core_idle[3] = 1'b0;
    tick();
    core_idle[1] = 1'b1; core_idle[3] = 1'b1;
    claim_reg[0] = 4; claim_valid[0] = 1'b1;
    #1;
    n_checks++; if (claim_ready[0] !== 1'b0) begin n_fail++; $display("FAIL sim_claim_on_completing: got %b expected 0", claim_ready[0]); end
    claim_valid[0] = 1'b0;
    own_q.push_back('{idx: 4, core: 1});
    own_q.push_back('{idx: 9, core: 3});
    sync_q.push_back(4'b1111);
    tick();
    pop_owners("sim");
    n_checks++; if (busy_table[4] !== 1'b0 || busy_table[9] !== 1'b0) begin n_fail++; $display("FAIL sim_busy_clr: got %b%b expected 00", busy_table[4], busy_table[9]); end
    wait_sync(cyc);
    exp_sync = sync_q.pop_front();
    n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL sim_sync_latency: got %0d expected 1", cyc); end
    n_checks++; if (sync_pulse !== exp_sync) begin n_fail++; $display("FAIL sim_sync_mask: got %b expected %b", sync_pulse, exp_sync); end
    tick();
    n_checks++; if (all_synced !== 1'b1 || sync_pulse !== '0) begin n_fail++; $display("FAIL sim_after_sync: all_synced %b sync %b expected 1 0", all_synced, sync_pulse); end
  endtask

  task automatic test_reset_mid();
    claim_reg[2] = 3; claim_valid[2] = 1'b1;
    tick();
    claim_valid[2] = 1'b0;
    core_idle[2] = 1'b0;
    tick();
    tick();
    n_checks++; if (busy_table[3] !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b expected 1", busy_table[3]); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy_table[3] !== 1'b0) begin n_fail++; $display("FAIL mid_busy3: got %b expected 0", busy_table[3]); end
    n_checks++; if (owner[3] !== '0 || owner[4] !== '0 || owner[9] !== '0) begin n_fail++; $display("FAIL mid_owner: got %0d %0d %0d expected 0 0 0", owner[3], owner[4], owner[9]); end
    n_checks++; if (sync_pulse !== '0 || all_synced !== 1'b1) begin n_fail++; $display("FAIL mid_sync: sync %b all_synced %b expected 0 1", sync_pulse, all_synced); end
    tick();
    rst_n = 1'b1;
    claim_valid[2] = 1'b1;
    #1;
    n_checks++; if (claim_ready[2] !== 1'b1) begin n_fail++; $display("FAIL mid_reclaim_ready: got %b expected 1", claim_ready[2]); end
    tick();
    claim_valid[2] = 1'b0;
    n_checks++; if (busy_table[3] !== 1'b1) begin n_fail++; $display("FAIL mid_reclaim_busy: got %b expected 1", busy_table[3]); end
  endtask

  initial begin
    claim_valid = '0;
    core_idle   = '1;
    ra_value    = 64'h0;
    for (int c = 0; c < NC; c++) begin
      claim_reg[c] = '0;
      for (int r = 0; r < RC; r++) begin
        core_regs[c][r] = 64'hC0DE_0000_0000_0000 | (64'(c + 1) << 32) | 64'(r);
      end
    end
    test_reset();
    test_single_claim();
    test_priority_and_stale();
    test_pinned();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
